// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   ic_state_t       : controller state encoding (IDLE, REQUEST, SERVICE)
//   VECTOR_SHIFT     : log2 of the IVT entry size in bytes (4-byte entries)
//   DEFAULT_IVT_BASE : reset-default base address of the interrupt vector table
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } ic_state_t;

  localparam int          VECTOR_SHIFT     = 2;
  localparam logic [31:0] DEFAULT_IVT_BASE = 32'h0000_0000;

endpackage

// File: rtl/interrupt_controller_priority_picker.sv
// Combinational winner selection between eligible internal and external lines.
//   internal     : eligible internal (exception) lines
//   external     : eligible external lines (already pending, masked, PSWI-gated)
//   index        : index of the winning line
//   internal_sel : 1 when the winner is an internal line
//   valid        : 1 when any line is eligible
// Lowest index wins; at equal index the internal line wins.
module interrupt_priority_picker
  #(
    parameter int WIDTH        = 16,
    parameter int NUMBER_WIDTH = 4
  )
  (
    input  logic [WIDTH-1:0]        internal,
    input  logic [WIDTH-1:0]        external,
    output logic [NUMBER_WIDTH-1:0] index,
    output logic                    internal_sel,
    output logic                    valid
  );

  // Scan from the top down so the last hit (lowest index) overwrites earlier
  // ones; internal is checked after external so it wins a tie.
  always_comb begin
    index        = '0;
    internal_sel = 1'b0;
    valid        = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (external[i]) begin
        index        = NUMBER_WIDTH'(i);
        internal_sel = 1'b0;
        valid        = 1'b1;
      end
      if (internal[i]) begin
        index        = NUMBER_WIDTH'(i);
        internal_sel = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Sequential interrupt controller.
//   clk, rst_n          : clock, asynchronous active-low reset
//   externalInterrupts  : rising-edge requests, latched into pending
//   internalInterrupts  : level requests, non-maskable, never latched
//   PSWI                : global enable for external lines
//   maskWrite/maskData  : load the per-line mask (1 = enabled)
//   ack, eoi            : CPU accept / end-of-interrupt pulses
//   irq                 : registered request to the CPU
//   interruptNumber     : vector number captured on accepted ack
//   address             : IVT_BASE + (interruptNumber << 2), captured on ack
//   inService           : high between accepted ack and eoi
//   dbgState/dbgPending : observation of FSM state and pending register
//
// Handshake: irq acts as "valid" and ack as "ready". A transfer happens on a
// rising edge where irq = 1 (state REQUEST, a line still eligible) and ack = 1;
// the winner of that cycle is captured and irq drops. eoi is honoured only in
// SERVICE; ack outside REQUEST and eoi outside SERVICE are ignored.
module interrupt_controller
  import interrupt_controller_pkg::*;
  #(
    parameter int                       WIDTH         = 16,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       NUMBER_WIDTH  = 4,  // 2**NUMBER_WIDTH >= WIDTH
    parameter logic [ADDRESS_WIDTH-1:0] IVT_BASE      = ADDRESS_WIDTH'(DEFAULT_IVT_BASE)
  )
  (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         externalInterrupts,
    input  logic [WIDTH-1:0]         internalInterrupts,
    input  logic                     PSWI,
    input  logic                     maskWrite,
    input  logic [WIDTH-1:0]         maskData,
    input  logic                     ack,
    input  logic                     eoi,
    output logic                     irq,
    output logic [NUMBER_WIDTH-1:0]  interruptNumber,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     inService,
    output ic_state_t                dbgState,
    output logic [WIDTH-1:0]         dbgPending
  );

  ic_state_t               state, state_next;
  logic [WIDTH-1:0]        pending, ext_prev, mask;
  logic [WIDTH-1:0]        elig_ext, edge_set, ack_clr;
  logic [NUMBER_WIDTH-1:0] win_index;
  logic                    win_internal, win_valid, accept;

  assign elig_ext = pending & mask & {WIDTH{PSWI}};
  assign edge_set = externalInterrupts & ~ext_prev;

  interrupt_priority_picker #(
    .WIDTH        (WIDTH),
    .NUMBER_WIDTH (NUMBER_WIDTH)
  ) u_picker (
    .internal     (internalInterrupts),
    .external     (elig_ext),
    .index        (win_index),
    .internal_sel (win_internal),
    .valid        (win_valid)
  );

  // An ack only counts if something is still eligible this very cycle.
  assign accept  = (state == REQUEST) && win_valid && ack;
  assign ack_clr = (accept && !win_internal) ? (WIDTH'(1) << win_index) : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid) state_next = REQUEST;
      REQUEST: begin
        if (!win_valid)  state_next = IDLE;
        else if (ack)    state_next = SERVICE;
      end
      SERVICE: if (eoi) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pending         <= '0;
      ext_prev        <= '0;
      mask            <= '1;
      irq             <= 1'b0;
      inService       <= 1'b0;
      interruptNumber <= '0;
      address         <= IVT_BASE;
    end else begin
      state     <= state_next;
      ext_prev  <= externalInterrupts;
      // Set after clear: a new edge on the line being acknowledged survives.
      pending   <= (pending & ~ack_clr) | edge_set;
      irq       <= (state_next == REQUEST);
      inService <= (state_next == SERVICE);
      if (maskWrite) mask <= maskData;
      if (accept) begin
        interruptNumber <= win_index;
        address         <= IVT_BASE + (ADDRESS_WIDTH'(win_index) << VECTOR_SHIFT);
      end
    end
  end

  assign dbgState   = state;
  assign dbgPending = pending;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  localparam int W  = 16;
  localparam int AW = 32;
  localparam int NW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  ext, intr, mask_data;
  logic          pswi, mask_write, ack, eoi;
  logic          irq, in_service;
  logic [NW-1:0] number;
  logic [AW-1:0] address;
  ic_state_t     dbg_state;
  logic [W-1:0]  dbg_pending;

  int total = 0;
  int bad   = 0;

  interrupt_controller #(
    .WIDTH(W), .ADDRESS_WIDTH(AW), .NUMBER_WIDTH(NW), .IVT_BASE(32'h0)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .externalInterrupts (ext),
    .internalInterrupts (intr),
    .PSWI               (pswi),
    .maskWrite          (mask_write),
    .maskData           (mask_data),
    .ack                (ack),
    .eoi                (eoi),
    .irq                (irq),
    .interruptNumber    (number),
    .address            (address),
    .inService          (in_service),
    .dbgState           (dbg_state),
    .dbgPending         (dbg_pending)
  );

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ext(input int idx);
    ext[idx] = 1'b1;
    step();
    ext[idx] = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %0b want 0", irq); end
    total++; if (number !== 4'd0) begin bad++; $display("FAIL reset_number: got %0d want 0", number); end
    total++; if (address !== 32'h0) begin bad++; $display("FAIL reset_address: got %h want 0", address); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL reset_inservice: got %0b want 0", in_service); end
    total++; if (dbg_pending !== 16'h0) begin bad++; $display("FAIL reset_pending: got %h want 0", dbg_pending); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_basic();
    pulse_ext(5);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_latency1: got %0b want 0", irq); end
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq_latency2: got %0b want 1", irq); end
    pulse_ack();
    total++; if (number !== 4'd5) begin bad++; $display("FAIL basic_number: got %0d want 5", number); end
    total++; if (address !== 32'h14) begin bad++; $display("FAIL basic_address: got %h want 14", address); end
    total++; if (dbg_pending[5] !== 1'b0) begin bad++; $display("FAIL basic_pending_clr: got %0b want 0", dbg_pending[5]); end
    total++; if (irq !== 1'b0 || in_service !== 1'b1) begin bad++; $display("FAIL basic_service: irq=%0b insvc=%0b want 0/1", irq, in_service); end
    pulse_eoi();
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL basic_eoi: got %0b want 0", in_service); end
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_after_eoi: got %0b want 0", irq); end
  endtask

  task automatic test_priority();
    ext  = 16'h0208;  // lines 3 and 9
    intr = 16'h1000;  // line 12
    step();
    ext = '0;
    step();
    pulse_ack();
    total++; if (number !== 4'd3) begin bad++; $display("FAIL prio_first: got %0d want 3", number); end
    total++; if (dbg_pending !== 16'h0200) begin bad++; $display("FAIL prio_pending: got %h want 0200", dbg_pending); end
    pulse_eoi();
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_rerequest: got %0b want 1", irq); end
    pulse_ack();
    total++; if (number !== 4'd9) begin bad++; $display("FAIL prio_second: got %0d want 9", number); end
    total++; if (address !== 32'h24) begin bad++; $display("FAIL prio_second_addr: got %h want 24", address); end
    pulse_ext(3);     // accumulates during service
    intr = 16'h0004;  // internal line 2 replaces line 12
    pulse_eoi();
    step();
    pulse_ack();
    total++; if (number !== 4'd2) begin bad++; $display("FAIL prio_internal2: got %0d want 2", number); end
    total++; if (address !== 32'h08) begin bad++; $display("FAIL prio_internal2_addr: got %h want 08", address); end
    total++; if (dbg_pending !== 16'h0008) begin bad++; $display("FAIL prio_internal_noclr: got %h want 0008", dbg_pending); end
    intr = '0;
    pulse_eoi();
    step();
    pulse_ack();
    total++; if (number !== 4'd3) begin bad++; $display("FAIL prio_ext3_again: got %0d want 3", number); end
    pulse_eoi();
    step();
  endtask

  task automatic test_pswi();
    pswi = 1'b0;
    pulse_ext(1);
    step();
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL pswi_blocked: got %0b want 0", irq); end
    total++; if (dbg_pending !== 16'h0002) begin bad++; $display("FAIL pswi_pending: got %h want 0002", dbg_pending); end
    pswi = 1'b1;
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pswi_enable_irq: got %0b want 1", irq); end
    pulse_ack();
    total++; if (number !== 4'd1) begin bad++; $display("FAIL pswi_number: got %0d want 1", number); end
    pulse_eoi();
    pswi = 1'b0;
    intr = 16'h0080;
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pswi_internal_irq: got %0b want 1", irq); end
    pulse_ack();
    total++; if (number !== 4'd7 || address !== 32'h1c) begin bad++; $display("FAIL pswi_internal_vec: got %0d/%h want 7/1c", number, address); end
    intr = '0;
    pulse_eoi();
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL pswi_idle: got %0b want 0", irq); end
    pswi = 1'b1;
  endtask

  task automatic test_back_to_back();
    pulse_ext(4);
    step();
    ack    = 1'b1;
    ext[4] = 1'b1;    // new edge in the acknowledge cycle
    step();
    ack    = 1'b0;
    ext[4] = 1'b0;
    total++; if (number !== 4'd4) begin bad++; $display("FAIL b2b_number: got %0d want 4", number); end
    total++; if (dbg_pending[4] !== 1'b1) begin bad++; $display("FAIL b2b_set_wins: got %0b want 1", dbg_pending[4]); end
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL b2b_no_irq_in_service: got %0b want 0", irq); end
    pulse_eoi();
    total++; if (irq !== 1'b0 || dbg_state !== IDLE) begin bad++; $display("FAIL b2b_gap: irq=%0b state=%0d want 0/IDLE", irq, dbg_state); end
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL b2b_reraise: got %0b want 1", irq); end
    pulse_ack();
    pulse_eoi();
    step();
  endtask

  task automatic test_mask();
    pulse_ext(6);
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_req: got %0b want 1", irq); end
    mask_write = 1'b1;
    mask_data  = 16'hffbf;
    step();
    mask_write = 1'b0;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_delay: got %0b want 1", irq); end
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_drop: got %0b want 0", irq); end
    total++; if (dbg_pending[6] !== 1'b1) begin bad++; $display("FAIL mask_retain: got %0b want 1", dbg_pending[6]); end
    mask_write = 1'b1;
    mask_data  = 16'hffff;
    step();
    mask_write = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_restore_delay: got %0b want 0", irq); end
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_restore: got %0b want 1", irq); end
    pulse_ack();
    total++; if (number !== 4'd6) begin bad++; $display("FAIL mask_number: got %0d want 6", number); end
    pulse_eoi();
    step();
  endtask

  task automatic test_async_reset();
    pulse_ext(8);
    step();
    pulse_ack();
    pulse_ext(10);
    total++; if (in_service !== 1'b1 || dbg_pending !== 16'h0400) begin bad++; $display("FAIL rst_setup: insvc=%0b pend=%h want 1/0400", in_service, dbg_pending); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_service !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL rst_async_ctrl: insvc=%0b irq=%0b want 0/0", in_service, irq); end
    total++; if (number !== 4'd0 || address !== 32'h0) begin bad++; $display("FAIL rst_async_vec: got %0d/%h want 0/0", number, address); end
    total++; if (dbg_pending !== 16'h0) begin bad++; $display("FAIL rst_async_pending: got %h want 0", dbg_pending); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_requests_lost: got %0b want 0", irq); end
  endtask

  initial begin
    ext        = '0;
    intr       = '0;
    pswi       = 1'b1;
    mask_write = 1'b0;
    mask_data  = '0;
    ack        = 1'b0;
    eoi        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_priority();
    test_pswi();
    test_back_to_back();
    test_mask();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
